leaf_stream_bridge: RTL and testbench
=====================================

Name: leaf_stream_bridge

Overview:
- Parametrised channel bridge between the leaf interface's user-side ports and an HLS kernel's ap_vld/ap_ack stream ports.
- Generalises the fixed 3-in/3-out, 32-bit leaf wrapper to NUM_IN x NUM_OUT channels of PAYLOAD_BITS each.
- Adds a per-channel elastic FIFO in each direction, per-channel transfer counters, and a gated kernel-start sequencer.
- Sits between leaf_interface and the user kernel inside each leaf's top.

Parameters:
PAYLOAD_BITS, 32, data width of every channel
NUM_IN, 3, channels from interface to kernel
NUM_OUT, 3, channels from kernel to interface
DEPTH, 4, FIFO entries per channel; power of 2, minimum 2
START_DELAY, 16, cycles after reset release before ap_start may propagate; 0 allowed
CNT_BITS, 32, width of each transfer counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ap_start_in  in  1  start request from leaf top
ap_start  out  1  start to kernel
if_din  in  NUM_IN*PAYLOAD_BITS  interface->bridge data; channel i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
if_vld  in  NUM_IN  interface data valid
if_ack  out  NUM_IN  bridge accepts interface data
k_dout  out  NUM_IN*PAYLOAD_BITS  data to kernel Input_i
k_vld  out  NUM_IN  to Input_i_ap_vld
k_ack  in  NUM_IN  from Input_i_ap_ack
k_din  in  NUM_OUT*PAYLOAD_BITS  data from kernel Output_i
k_din_vld  in  NUM_OUT  from Output_i_ap_vld
k_din_ack  out  NUM_OUT  to Output_i_ap_ack
if_dout  out  NUM_OUT*PAYLOAD_BITS  bridge->interface data
if_dout_vld  out  NUM_OUT  bridge data valid to interface
if_dout_ack  in  NUM_OUT  interface accepts
rx_count  out  NUM_IN*CNT_BITS  words delivered to kernel, per channel
tx_count  out  NUM_OUT*CNT_BITS  words accepted from kernel, per channel

Behaviour:
- Transfer on any link: vld & ack high in the same clk edge. No other condition counts.
- One independent FIFO per channel: in-FIFO i (if_* -> k_*), out-FIFO j (k_din* -> if_dout*).
- FIFO occupancy register, width clog2(DEPTH)+1; read/write pointers wrap modulo DEPTH.
- ack toward producer (if_ack, k_din_ack) = (occupancy != DEPTH); registered-state-derived; no combinational path from the producer's vld.
- vld toward consumer (k_vld, if_dout_vld) = (occupancy != 0). Data = head entry, first-word fall-through.
- Latency: word pushed at edge N is visible with vld high after edge N (one cycle).
- Full with simultaneous pop: ack is low, so no push; pop proceeds; ack rises next cycle.
- Empty with simultaneous push: no pop; vld rises next cycle.
- Push and pop in the same cycle at 0 < occupancy < DEPTH: occupancy unchanged; order preserved.
- Head data holds stable while vld is high and ack is low.
- rx_count[i] increments on each k_vld & k_ack transfer.
- tx_count[j] increments on each k_din_vld & k_din_ack transfer.
- Counters wrap to 0 after 2^CNT_BITS-1.
- Start sequencer FSM:
  - WAIT: counts START_DELAY cycles after reset release; ap_start=0. Goes to RUN on count == START_DELAY-1, or immediately if START_DELAY=0.
  - RUN: ap_start = ap_start_in, registered, 1-cycle latency.
- Reset, including mid-operation:
  - All FIFOs emptied; pointers and occupancy 0; in-flight words discarded.
  - Counters 0; FSM to WAIT.
  - Outputs during and immediately after reset: if_ack=all 1, k_din_ack=all 1, k_vld=0, if_dout_vld=0, ap_start=0.
  - Data outputs don't-care while vld is low; FIFO storage needs no reset.

Test Plan:
- Reset release, START_DELAY=16, ap_start_in=1 from cycle 0 -> ap_start low for 16 cycles, high from cycle 17; with START_DELAY=0, high 1 cycle after release.
- Channel 1 in, k_ack held 0, push 0x11,0x22,0x33,0x44 back-to-back (DEPTH=4) -> if_ack drops after the 4th push. Release k_ack -> kernel receives 0x11..0x44 in order; rx_count[1]=4; if_ack high again after the first pop.
- Full in-FIFO 0, if_vld=1 and k_ack=1 same cycle -> no push that cycle, one pop, occupancy 3; next cycle push accepted.
- Out-channel 2 streaming with if_dout_ack toggling 1,0,1,0 over 100 words 0..99 -> all 100 delivered in order, none duplicated; tx_count[2]=100.
- Reset asserted with 3 words in out-FIFO 0 -> next cycle if_dout_vld=0, tx_count=0, k_din_ack=1; post-reset push of 0xAB emerges alone.
- CNT_BITS=4, 17 transfers on in-channel 0 -> rx_count[0]=1 (wrap).

Source files
------------

// File: rtl/leaf_stream_bridge.sv
// leaf_stream_bridge: elastic per-channel bridge between leaf user ports and HLS ap_vld/ap_ack streams
// Ports: clk/reset; ap_start_in -> ap_start (gated by a post-reset delay);
//   if_din/if_vld/if_ack -> in-FIFOs -> k_dout/k_vld/k_ack (NUM_IN channels);
//   k_din/k_din_vld/k_din_ack -> out-FIFOs -> if_dout/if_dout_vld/if_dout_ack (NUM_OUT channels);
//   rx_count/tx_count: per-channel transfer counters on the kernel side.
module leaf_stream_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  input  logic         in_vld,
  output logic         in_ack,
  output logic [W-1:0] dout,
  output logic         out_vld,
  input  logic         out_ack
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] occ;
  logic push, pop;
  // ack depends only on registered occupancy, never on the producer's vld
  assign in_ack = occ != (AW+1)'(DEPTH);
  assign out_vld = occ != '0;
  assign dout = mem[rp];
  assign push = in_vld & in_ack;
  assign pop = out_vld & out_ack;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      occ <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

module leaf_stream_bridge #(
  parameter int PAYLOAD_BITS = 32,
  parameter int NUM_IN = 3,
  parameter int NUM_OUT = 3,
  parameter int DEPTH = 4,
  parameter int START_DELAY = 16,
  parameter int CNT_BITS = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ap_start_in,
  output logic                            ap_start,
  input  logic [NUM_IN*PAYLOAD_BITS-1:0]  if_din,
  input  logic [NUM_IN-1:0]               if_vld,
  output logic [NUM_IN-1:0]               if_ack,
  output logic [NUM_IN*PAYLOAD_BITS-1:0]  k_dout,
  output logic [NUM_IN-1:0]               k_vld,
  input  logic [NUM_IN-1:0]               k_ack,
  input  logic [NUM_OUT*PAYLOAD_BITS-1:0] k_din,
  input  logic [NUM_OUT-1:0]              k_din_vld,
  output logic [NUM_OUT-1:0]              k_din_ack,
  output logic [NUM_OUT*PAYLOAD_BITS-1:0] if_dout,
  output logic [NUM_OUT-1:0]              if_dout_vld,
  input  logic [NUM_OUT-1:0]              if_dout_ack,
  output logic [NUM_IN*CNT_BITS-1:0]      rx_count,
  output logic [NUM_OUT*CNT_BITS-1:0]     tx_count
);
  localparam int PB = PAYLOAD_BITS;
  localparam int CB = CNT_BITS;
  localparam int DW = START_DELAY > 1 ? $clog2(START_DELAY) : 1;
  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    logic [CB-1:0] cnt;
    leaf_stream_fifo #(.W(PB), .DEPTH(DEPTH)) u_fifo (
      .clk(clk), .reset(reset),
      .din(if_din[i*PB +: PB]), .in_vld(if_vld[i]), .in_ack(if_ack[i]),
      .dout(k_dout[i*PB +: PB]), .out_vld(k_vld[i]), .out_ack(k_ack[i])
    );
    always_ff @(posedge clk)
      if (reset) cnt <= '0;
      else if (k_vld[i] & k_ack[i]) cnt <= cnt + 1'b1;
    assign rx_count[i*CB +: CB] = cnt;
  end
  for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
    logic [CB-1:0] cnt;
    leaf_stream_fifo #(.W(PB), .DEPTH(DEPTH)) u_fifo (
      .clk(clk), .reset(reset),
      .din(k_din[j*PB +: PB]), .in_vld(k_din_vld[j]), .in_ack(k_din_ack[j]),
      .dout(if_dout[j*PB +: PB]), .out_vld(if_dout_vld[j]), .out_ack(if_dout_ack[j])
    );
    always_ff @(posedge clk)
      if (reset) cnt <= '0;
      else if (k_din_vld[j] & k_din_ack[j]) cnt <= cnt + 1'b1;
    assign tx_count[j*CB +: CB] = cnt;
  end
  typedef enum logic {WAIT, RUN} state_t;
  state_t st;
  logic [DW-1:0] dcnt;
  // with no delay the start path is open from the first cycle after reset
  always_ff @(posedge clk)
    if (reset) begin
      st <= WAIT;
      dcnt <= '0;
      ap_start <= 1'b0;
    end else begin
      ap_start <= (st == RUN || START_DELAY == 0) & ap_start_in;
      if (st == WAIT) begin
        if (START_DELAY == 0 || dcnt == DW'(START_DELAY - 1)) st <= RUN;
        dcnt <= dcnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_leaf_stream_bridge.sv
// tb_leaf_stream_bridge: scoreboard bench for leaf_stream_bridge
module tb_leaf_stream_bridge;
  logic clk = 0, reset = 1, ap_start_in = 0;
  logic [95:0] if_din = '0, k_din = '0;
  logic [2:0] if_vld = '0, k_ack = '0, k_din_vld = '0, if_dout_ack = '0;
  logic ap_start;
  logic [2:0] if_ack, k_vld, k_din_ack, if_dout_vld;
  logic [95:0] k_dout, if_dout, rx_count, tx_count;
  logic ap_start_in2 = 0;
  logic [95:0] if_din2 = '0, k_din2 = '0;
  logic [2:0] if_vld2 = '0, k_ack2 = '0, k_din_vld2 = '0, if_dout_ack2 = '0;
  logic ap_start2;
  logic [2:0] if_ack2, k_vld2, k_din_ack2, if_dout_vld2;
  logic [95:0] k_dout2, if_dout2;
  logic [11:0] rx_count2, tx_count2;
  int checks = 0, errors = 0;
  int rcv_out [3];
  logic [31:0] q_in [3][$];
  logic [31:0] q_out [3][$];
  logic [31:0] e;

  always #5 clk = ~clk;

  leaf_stream_bridge dut (
    .clk(clk), .reset(reset), .ap_start_in(ap_start_in), .ap_start(ap_start),
    .if_din(if_din), .if_vld(if_vld), .if_ack(if_ack),
    .k_dout(k_dout), .k_vld(k_vld), .k_ack(k_ack),
    .k_din(k_din), .k_din_vld(k_din_vld), .k_din_ack(k_din_ack),
    .if_dout(if_dout), .if_dout_vld(if_dout_vld), .if_dout_ack(if_dout_ack),
    .rx_count(rx_count), .tx_count(tx_count)
  );

  leaf_stream_bridge #(.START_DELAY(0), .CNT_BITS(4)) dut2 (
    .clk(clk), .reset(reset), .ap_start_in(ap_start_in2), .ap_start(ap_start2),
    .if_din(if_din2), .if_vld(if_vld2), .if_ack(if_ack2),
    .k_dout(k_dout2), .k_vld(k_vld2), .k_ack(k_ack2),
    .k_din(k_din2), .k_din_vld(k_din_vld2), .k_din_ack(k_din_ack2),
    .if_dout(if_dout2), .if_dout_vld(if_dout_vld2), .if_dout_ack(if_dout_ack2),
    .rx_count(rx_count2), .tx_count(tx_count2)
  );

  // Handshake signals are stable at negedge; they describe the transfers of the next posedge.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        q_in[i].delete();
        q_out[i].delete();
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (k_vld[i] && k_ack[i]) begin
          checks++;
          if (q_in[i].size() == 0) begin
            errors++;
            $display("FAIL in%0d_data: got %h, expected nothing", i, k_dout[i*32 +: 32]);
          end else begin
            e = q_in[i].pop_front();
            if (k_dout[i*32 +: 32] !== e) begin
              errors++;
              $display("FAIL in%0d_data: got %h, expected %h", i, k_dout[i*32 +: 32], e);
            end
          end
        end
        if (if_vld[i] && if_ack[i]) q_in[i].push_back(if_din[i*32 +: 32]);
        if (if_dout_vld[i] && if_dout_ack[i]) begin
          checks++;
          rcv_out[i]++;
          if (q_out[i].size() == 0) begin
            errors++;
            $display("FAIL out%0d_data: got %h, expected nothing", i, if_dout[i*32 +: 32]);
          end else begin
            e = q_out[i].pop_front();
            if (if_dout[i*32 +: 32] !== e) begin
              errors++;
              $display("FAIL out%0d_data: got %h, expected %h", i, if_dout[i*32 +: 32], e);
            end
          end
        end
        if (k_din_vld[i] && k_din_ack[i]) q_out[i].push_back(k_din[i*32 +: 32]);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1;
    tick;
    tick;
    checks++;
    if (if_ack !== 3'b111 || k_din_ack !== 3'b111) begin
      errors++;
      $display("FAIL reset_ack: if_ack=%b k_din_ack=%b, expected 111 111", if_ack, k_din_ack);
    end
    checks++;
    if (k_vld !== 3'b000 || if_dout_vld !== 3'b000 || ap_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_vld: k_vld=%b if_dout_vld=%b ap_start=%b, expected 000 000 0", k_vld, if_dout_vld, ap_start);
    end
    checks++;
    if (rx_count !== '0 || tx_count !== '0) begin
      errors++;
      $display("FAIL reset_cnt: rx=%h tx=%h, expected 0", rx_count, tx_count);
    end
  endtask

  task automatic test_start;
    ap_start_in = 1;
    ap_start_in2 = 1;
    reset = 0;
    for (int c = 1; c <= 20; c++) begin
      tick;
      checks++;
      if (ap_start !== (c >= 17)) begin
        errors++;
        $display("FAIL start_delay16 cycle %0d: got %b, expected %b", c, ap_start, c >= 17);
      end
      checks++;
      if (ap_start2 !== 1'b1) begin
        errors++;
        $display("FAIL start_delay0 cycle %0d: got %b, expected 1", c, ap_start2);
      end
    end
  endtask

  task automatic test_fill;
    logic [31:0] w [4];
    w = '{32'h11, 32'h22, 32'h33, 32'h44};
    k_ack[1] = 0;
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (if_ack[1] !== 1'b1) begin
        errors++;
        $display("FAIL fill_ack before push %0d: got %b, expected 1", n, if_ack[1]);
      end
      if_din[32 +: 32] = w[n];
      if_vld[1] = 1;
      tick;
    end
    if_vld[1] = 0;
    checks++;
    if (if_ack[1] !== 1'b0 || k_vld[1] !== 1'b1 || k_dout[32 +: 32] !== 32'h11) begin
      errors++;
      $display("FAIL fill_full: ack=%b vld=%b head=%h, expected 0 1 00000011", if_ack[1], k_vld[1], k_dout[32 +: 32]);
    end
    k_ack[1] = 1;
    tick;
    checks++;
    if (if_ack[1] !== 1'b1) begin
      errors++;
      $display("FAIL fill_ack_after_pop: got %b, expected 1", if_ack[1]);
    end
    for (int n = 0; n < 10 && k_vld[1]; n++) tick;
    k_ack[1] = 0;
    checks++;
    if (rx_count[32 +: 32] !== 32'd4 || q_in[1].size() != 0) begin
      errors++;
      $display("FAIL fill_rx_count: got %0d pending %0d, expected 4 pending 0", rx_count[32 +: 32], q_in[1].size());
    end
  endtask

  task automatic test_full_pop;
    k_ack[0] = 0;
    for (int n = 0; n < 4; n++) begin
      if_din[31:0] = 32'hA0 + n;
      if_vld[0] = 1;
      tick;
    end
    if_din[31:0] = 32'hB0;
    k_ack[0] = 1;
    checks++;
    if (if_ack[0] !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_ack_full: got %b, expected 0", if_ack[0]);
    end
    tick;
    checks++;
    if (if_ack[0] !== 1'b1 || k_dout[31:0] !== 32'hA1) begin
      errors++;
      $display("FAIL fullpop_after: ack=%b head=%h, expected 1 000000a1", if_ack[0], k_dout[31:0]);
    end
    k_ack[0] = 0;
    tick;
    if_vld[0] = 0;
    checks++;
    if (if_ack[0] !== 1'b0 || k_dout[31:0] !== 32'hA1) begin
      errors++;
      $display("FAIL fullpop_refill: ack=%b head=%h, expected 0 000000a1", if_ack[0], k_dout[31:0]);
    end
    k_ack[0] = 1;
    for (int n = 0; n < 10 && k_vld[0]; n++) tick;
    k_ack[0] = 0;
    checks++;
    if (rx_count[31:0] !== 32'd5 || q_in[0].size() != 0) begin
      errors++;
      $display("FAIL fullpop_rx_count: got %0d pending %0d, expected 5 pending 0", rx_count[31:0], q_in[0].size());
    end
  endtask

  task automatic test_stream;
    int sent;
    logic go;
    sent = 0;
    rcv_out[2] = 0;
    for (int c = 0; c < 1000 && rcv_out[2] < 100; c++) begin
      if_dout_ack[2] = (c % 2 == 0);
      k_din_vld[2] = sent < 100;
      k_din[64 +: 32] = sent;
      go = k_din_vld[2] & k_din_ack[2];
      tick;
      if (go) sent++;
    end
    k_din_vld[2] = 0;
    if_dout_ack[2] = 0;
    checks++;
    if (rcv_out[2] != 100 || q_out[2].size() != 0) begin
      errors++;
      $display("FAIL stream_delivered: got %0d pending %0d, expected 100 pending 0", rcv_out[2], q_out[2].size());
    end
    checks++;
    if (tx_count[64 +: 32] !== 32'd100) begin
      errors++;
      $display("FAIL stream_tx_count: got %0d, expected 100", tx_count[64 +: 32]);
    end
  endtask

  task automatic test_wrap;
    int n;
    n = 0;
    if_vld2[0] = 1;
    for (int c = 0; c < 200 && n < 17; c++) begin
      k_ack2[0] = 1;
      if (k_vld2[0]) begin
        tick;
        n++;
        if (n == 16) begin
          checks++;
          if (rx_count2[3:0] !== 4'd0) begin
            errors++;
            $display("FAIL wrap_16: got %0d, expected 0", rx_count2[3:0]);
          end
        end
      end else tick;
    end
    k_ack2[0] = 0;
    if_vld2[0] = 0;
    tick;
    checks++;
    if (n != 17 || rx_count2[3:0] !== 4'd1) begin
      errors++;
      $display("FAIL wrap_17: transfers %0d count %0d, expected 17 and 1", n, rx_count2[3:0]);
    end
  endtask

  task automatic test_reset_mid;
    if_dout_ack[0] = 0;
    for (int n = 0; n < 3; n++) begin
      k_din[31:0] = 32'hC0 + n;
      k_din_vld[0] = 1;
      tick;
    end
    k_din_vld[0] = 0;
    checks++;
    if (if_dout_vld[0] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: vld=%b, expected 1", if_dout_vld[0]);
    end
    reset = 1;
    tick;
    checks++;
    if (if_dout_vld !== 3'b000 || tx_count !== '0 || k_din_ack !== 3'b111) begin
      errors++;
      $display("FAIL midreset: vld=%b tx=%h ack=%b, expected 000 0 111", if_dout_vld, tx_count, k_din_ack);
    end
    checks++;
    if (if_ack !== 3'b111 || k_vld !== 3'b000 || ap_start !== 1'b0) begin
      errors++;
      $display("FAIL midreset_other: if_ack=%b k_vld=%b ap_start=%b, expected 111 000 0", if_ack, k_vld, ap_start);
    end
    reset = 0;
    tick;
    k_din[31:0] = 32'hAB;
    k_din_vld[0] = 1;
    if_dout_ack[0] = 1;
    tick;
    k_din_vld[0] = 0;
    checks++;
    if (if_dout_vld[0] !== 1'b1 || if_dout[31:0] !== 32'hAB) begin
      errors++;
      $display("FAIL midreset_ab: vld=%b data=%h, expected 1 000000ab", if_dout_vld[0], if_dout[31:0]);
    end
    tick;
    if_dout_ack[0] = 0;
    checks++;
    if (if_dout_vld[0] !== 1'b0 || tx_count[31:0] !== 32'd1) begin
      errors++;
      $display("FAIL midreset_alone: vld=%b tx=%0d, expected 0 1", if_dout_vld[0], tx_count[31:0]);
    end
  endtask

  initial begin
    test_reset;
    test_start;
    test_fill;
    test_full_pop;
    test_stream;
    test_wrap;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
